// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the bit-serial ALU.
package alu_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;  // acts on data_in_1 only

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_bit_serial_seq.sv
// Operand sequencer turning an external combinational 1-bit ALU into a W-bit
// bit-serial ALU with a start/done handshake; operands are presented LSB first.
module alu_bit_serial_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero,
  output logic [1:0]   alu_ctrl,
  output logic         alu_in_1,
  output logic         alu_in_2,
  input  logic         alu_data_out,
  input  logic         alu_zero_flag
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state, state_nx;
  logic [W-1:0]   sa, sb, acc, acc_nx;
  logic [1:0]     op_q;
  logic [CW-1:0]  cnt;
  logic           zacc, zacc_nx;

  always_comb begin
    acc_nx  = {alu_data_out, acc[W-1:1]};
    zacc_nx = zacc & alu_zero_flag;
  end

  // The last RUN edge loads result/zero from the next-accumulator values so
  // they are already valid during the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      zacc   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            op_q <= op;
            cnt  <= '0;
            zacc <= 1'b1;
            acc  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_nx;
          zacc <= zacc_nx;
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            result <= acc_nx;
            zero   <= zacc_nx;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    alu_in_1 = 1'b0;
    alu_in_2 = 1'b0;
    alu_ctrl = op_q;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy     = 1'b1;
        alu_in_1 = sa[0];
        alu_in_2 = sb[0];
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// Self-checking bench: three sequencers (W=2, 8, 32) each wired to a behavioural
// 1-bit ALU, checked against word-level reference results.
module tb_alu_bit_serial_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a32, b32;

  logic        busy8, done8, zero8, in1_8, in2_8, dout8, zf8;
  logic [7:0]  res8;
  logic [1:0]  ctrl8;
  logic        busy2, done2, zero2, in1_2, in2_2, dout2, zf2;
  logic [1:0]  res2;
  logic [1:0]  ctrl2;
  logic        busy32, done32, zero32, in1_32, in2_32, dout32, zf32;
  logic [31:0] res32;
  logic [1:0]  ctrl32;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic alu_bit(input logic [1:0] c, input logic x, input logic y);
    case (c)
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      default: return ~x;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [1:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_XOR: return x ^ y;
      default: return ~x;
    endcase
  endfunction

  assign dout8  = alu_bit(ctrl8, in1_8, in2_8);
  assign zf8    = ~dout8;
  assign dout2  = alu_bit(ctrl2, in1_2, in2_2);
  assign zf2    = ~dout2;
  assign dout32 = alu_bit(ctrl32, in1_32, in2_32);
  assign zf32   = ~dout32;

  alu_bit_serial_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a32[7:0]), .b(b32[7:0]),
    .busy(busy8), .done(done8), .result(res8), .zero(zero8), .alu_ctrl(ctrl8),
    .alu_in_1(in1_8), .alu_in_2(in2_8), .alu_data_out(dout8), .alu_zero_flag(zf8));

  alu_bit_serial_seq #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a32[1:0]), .b(b32[1:0]),
    .busy(busy2), .done(done2), .result(res2), .zero(zero2), .alu_ctrl(ctrl2),
    .alu_in_1(in1_2), .alu_in_2(in2_2), .alu_data_out(dout2), .alu_zero_flag(zf2));

  alu_bit_serial_seq #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .zero(zero32), .alu_ctrl(ctrl32),
    .alu_in_1(in1_32), .alu_in_2(in2_32), .alu_data_out(dout32), .alu_zero_flag(zf32));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one request to the W=8 instance and waits (bounded) for done.
  // lat counts edges after the start-sampling edge until done is seen.
  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      input bit noise, output logic [7:0] res, output logic z,
                      output int lat, output int busy_n, output logic [7:0] in1_seq);
    op = o; a32 = {24'h0, x}; b32 = {24'h0, y}; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0; busy_n = 0; in1_seq = '0;
    while (!done8 && lat < 40) begin
      if (busy8) begin
        busy_n++;
        if (lat < 8) in1_seq[lat] = in1_8;
      end
      if (noise) begin
        start = 1'b1; op = 2'($urandom); a32 = $urandom; b32 = $urandom;
      end
      tick;
      lat++;
    end
    res = res8;
    z = zero8;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; a32 = '0; b32 = '0;
    tick; tick;
    n_cmp++; if (busy8 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_cmp++; if (done8 !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
    n_cmp++; if (res8 !== 8'h00)   begin n_fail++; $display("FAIL reset_result got %h want 00", res8); end
    n_cmp++; if (zero8 !== 1'b0)   begin n_fail++; $display("FAIL reset_zero got %b want 0", zero8); end
    n_cmp++; if (ctrl8 !== 2'b00)  begin n_fail++; $display("FAIL reset_ctrl got %b want 00", ctrl8); end
    n_cmp++; if ({in1_8, in2_8} !== 2'b00) begin n_fail++; $display("FAIL reset_alu_in got %b want 00", {in1_8, in2_8}); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_and;
    logic [7:0] r, s; logic z; int lat, bn;
    run8(ALU_AND, 8'hF0, 8'h3C, 1'b0, r, z, lat, bn, s);
    n_cmp++; if (bn != 8)      begin n_fail++; $display("FAIL and_busy_cycles got %0d want 8", bn); end
    n_cmp++; if (lat != 8)     begin n_fail++; $display("FAIL and_latency got %0d want 8", lat); end
    n_cmp++; if (r !== 8'h30)  begin n_fail++; $display("FAIL and_result got %h want 30", r); end
    n_cmp++; if (z !== 1'b0)   begin n_fail++; $display("FAIL and_zero got %b want 0", z); end
    tick;
    n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL and_done_pulse got %b want 0", done8); end
    n_cmp++; if (res8 !== 8'h30) begin n_fail++; $display("FAIL and_result_hold got %h want 30", res8); end
    n_cmp++; if ({in1_8, in2_8} !== 2'b00) begin n_fail++; $display("FAIL and_idle_alu_in got %b want 00", {in1_8, in2_8}); end
    n_cmp++; if (ctrl8 !== ALU_AND) begin n_fail++; $display("FAIL and_idle_ctrl got %b want 00", ctrl8); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] r, s; logic z; int lat, bn;
    run8(ALU_XOR, 8'hA5, 8'hA5, 1'b0, r, z, lat, bn, s);
    n_cmp++; if (r !== 8'h00) begin n_fail++; $display("FAIL xor_result got %h want 00", r); end
    n_cmp++; if (z !== 1'b1)  begin n_fail++; $display("FAIL xor_zero got %b want 1", z); end
    tick;
    run8(ALU_OR, 8'h01, 8'h80, 1'b0, r, z, lat, bn, s);
    n_cmp++; if (lat != 8)    begin n_fail++; $display("FAIL b2b_latency got %0d want 8", lat); end
    n_cmp++; if (r !== 8'h81) begin n_fail++; $display("FAIL or_result got %h want 81", r); end
    n_cmp++; if (z !== 1'b0)  begin n_fail++; $display("FAIL or_zero got %b want 0", z); end
    tick;
  endtask

  task automatic test_not_sequence;
    logic [7:0] r, s; logic z; int lat, bn;
    run8(ALU_NOT, 8'h0F, 8'($urandom), 1'b0, r, z, lat, bn, s);
    n_cmp++; if (s !== 8'h0F) begin n_fail++; $display("FAIL not_in1_seq got %b want 00001111 (bit0 first at right)", s); end
    n_cmp++; if (r !== 8'hF0) begin n_fail++; $display("FAIL not_result got %h want f0", r); end
    n_cmp++; if (z !== 1'b0)  begin n_fail++; $display("FAIL not_zero got %b want 0", z); end
    n_cmp++; if (ctrl8 !== ALU_NOT) begin n_fail++; $display("FAIL not_ctrl got %b want 11", ctrl8); end
    tick;
  endtask

  task automatic test_ignore_start;
    logic [7:0] r, s; logic z; int lat, bn, pulses;
    run8(ALU_AND, 8'hF0, 8'h3C, 1'b1, r, z, lat, bn, s);
    n_cmp++; if (lat != 8)    begin n_fail++; $display("FAIL ign_latency got %0d want 8", lat); end
    n_cmp++; if (r !== 8'h30) begin n_fail++; $display("FAIL ign_result got %h want 30", r); end
    start = 1'b1; op = ALU_OR; a32 = 32'hFF; b32 = 32'hFF;
    tick;
    start = 1'b0;
    n_cmp++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL ign_done_start got busy %b want 0", busy8); end
    pulses = 1;
    for (int i = 0; i < 12; i++) begin
      if (done8) pulses++;
      tick;
    end
    n_cmp++; if (pulses != 1)   begin n_fail++; $display("FAIL ign_done_count got %0d want 1", pulses); end
    n_cmp++; if (res8 !== 8'h30) begin n_fail++; $display("FAIL ign_result_hold got %h want 30", res8); end
  endtask

  task automatic test_rst_midrun;
    logic [7:0] r, s; logic z; int lat, bn, pulses;
    op = ALU_OR; a32 = 32'h5A; b32 = 32'h0F; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy8); end
    n_cmp++; if (res8 !== 8'h00) begin n_fail++; $display("FAIL rst_result got %h want 00", res8); end
    n_cmp++; if (zero8 !== 1'b0) begin n_fail++; $display("FAIL rst_zero got %b want 0", zero8); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) pulses++;
      tick;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rst_no_done got %0d want 0", pulses); end
    run8(ALU_XOR, 8'h3C, 8'h66, 1'b0, r, z, lat, bn, s);
    n_cmp++; if (r !== 8'h5A) begin n_fail++; $display("FAIL rst_fresh_result got %h want 5a", r); end
    n_cmp++; if (lat != 8)    begin n_fail++; $display("FAIL rst_fresh_latency got %0d want 8", lat); end
    tick;
  endtask

  task automatic test_sweep;
    logic [31:0] e, r32v; logic [7:0] r8v; logic [1:0] r2v;
    logic zz2, zz8, zz32;
    int l2, l8, l32, p2, p8, p32;
    for (int i = 0; i < 40; i++) tick;
    for (int t = 0; t < 20; t++) begin
      op = 2'($urandom_range(0, 2)); a32 = $urandom; b32 = $urandom;
      if (t == 0) b32 = ~a32;
      start = 1'b1;
      tick;
      start = 1'b0;
      l2 = -1; l8 = -1; l32 = -1; p2 = 0; p8 = 0; p32 = 0;
      r2v = '0; r8v = '0; r32v = '0; zz2 = 1'b0; zz8 = 1'b0; zz32 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        tick;
        if (done2)  begin p2++;  l2 = c;  r2v = res2;   zz2 = zero2;   end
        if (done8)  begin p8++;  l8 = c;  r8v = res8;   zz8 = zero8;   end
        if (done32) begin p32++; l32 = c; r32v = res32; zz32 = zero32; end
      end
      e = ref_word(op, a32, b32);
      n_cmp++; if (l2 != 2 || p2 != 1)   begin n_fail++; $display("FAIL sweep_w2_lat t=%0d got lat %0d pulses %0d want 2/1", t, l2, p2); end
      n_cmp++; if (r2v !== e[1:0])       begin n_fail++; $display("FAIL sweep_w2_result t=%0d got %h want %h", t, r2v, e[1:0]); end
      n_cmp++; if (zz2 !== (e[1:0] == 2'b0)) begin n_fail++; $display("FAIL sweep_w2_zero t=%0d got %b want %b", t, zz2, e[1:0] == 2'b0); end
      n_cmp++; if (l8 != 8 || p8 != 1)   begin n_fail++; $display("FAIL sweep_w8_lat t=%0d got lat %0d pulses %0d want 8/1", t, l8, p8); end
      n_cmp++; if (r8v !== e[7:0])       begin n_fail++; $display("FAIL sweep_w8_result t=%0d got %h want %h", t, r8v, e[7:0]); end
      n_cmp++; if (zz8 !== (e[7:0] == 8'h0)) begin n_fail++; $display("FAIL sweep_w8_zero t=%0d got %b want %b", t, zz8, e[7:0] == 8'h0); end
      n_cmp++; if (l32 != 32 || p32 != 1) begin n_fail++; $display("FAIL sweep_w32_lat t=%0d got lat %0d pulses %0d want 32/1", t, l32, p32); end
      n_cmp++; if (r32v !== e)           begin n_fail++; $display("FAIL sweep_w32_result t=%0d got %h want %h", t, r32v, e); end
      n_cmp++; if (zz32 !== (e == 32'h0)) begin n_fail++; $display("FAIL sweep_w32_zero t=%0d got %b want %b", t, zz32, e == 32'h0); end
    end
  endtask

  initial begin
    test_reset;
    test_and;
    test_back_to_back;
    test_not_sequence;
    test_ignore_start;
    test_rst_midrun;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
